// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one iteration per cycle; done pulses WIDTH cycles after accept (WIDTH+1 with the NEG fix-up).
// Starts are taken only while ready; define SEQ_MULTIPLIER_SIGNED_EN for two's-complement support via signed_mode.
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     multiplicand,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, NEG = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_t;
`endif

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       sum;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
   logic                 neg_q, neg_d;
   logic                 a_neg, b_neg;

   // Multiply magnitudes; the most-negative operand negates to itself, which is its correct unsigned magnitude.
   assign a_neg = signed_mode & multiplier[WIDTH-1];
   assign b_neg = signed_mode & multiplicand[WIDTH-1];
   assign a_mag = a_neg ? -multiplier : multiplier;
   assign b_mag = b_neg ? -multiplicand : multiplicand;
`else
   logic                 unused_signed_mode;

   assign unused_signed_mode = signed_mode;
   assign a_mag = multiplier;
   assign b_mag = multiplicand;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
         neg_q   <= neg_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      sum     = '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      neg_d   = neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               prod_d  = {{WIDTH{1'b0}}, a_mag};
               mcand_d = b_mag;
               cnt_d   = '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
               neg_d   = a_neg ^ b_neg;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            // Carry lands in the top bit after the right shift.
            sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
            prod_d = {sum, prod_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
               state_d = NEG;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef SEQ_MULTIPLIER_SIGNED_EN
         NEG: begin
            if (neg_q) begin
               prod_d = -prod_q;
            end
            state_d = DONE;
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ready   = (state_q == IDLE);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
   assign busy    = (state_q == RUN) || (state_q == NEG);
`else
   assign busy    = (state_q == RUN);
`endif
   assign done    = (state_q == DONE);
   assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random bench for seq_multiplier at WIDTH=32 and WIDTH=8, checked against an arithmetic reference.
module tb_seq_multiplier;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
   localparam int LAT32 = 33;
   localparam int LAT8  = 9;
`else
   localparam int LAT32 = 32;
   localparam int LAT8  = 8;
`endif

   logic        clk;
   logic        rst_n;

   logic        start32, sm32, ready32, busy32, done32;
   logic [31:0] a32, b32;
   logic [63:0] p32;

   logic        start8, sm8, ready8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int n_assert = 0;
   int n_fail   = 0;

   seq_multiplier #(.WIDTH(32)) dut32 (
      .clock(clk), .reset_n(rst_n), .start(start32), .signed_mode(sm32),
      .multiplier(a32), .multiplicand(b32),
      .ready(ready32), .busy(busy32), .done(done32), .product(p32)
   );

   seq_multiplier #(.WIDTH(8)) dut8 (
      .clock(clk), .reset_n(rst_n), .start(start8), .signed_mode(sm8),
      .multiplier(a8), .multiplicand(b8),
      .ready(ready8), .busy(busy8), .done(done8), .product(p8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer multiplication of the operands as the build interprets them.
   function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint x, y;
      x = longint'(a);
      y = longint'(b);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      if (s) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end
`else
      if (s) x = longint'(a);
`endif
      return 64'(x * y);
   endfunction

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
      int x, y;
      x = int'(a);
      y = int'(b);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      if (s) begin
         x = int'($signed(a));
         y = int'($signed(b));
      end
`else
      if (s) x = int'(a);
`endif
      return 16'(x * y);
   endfunction

   task automatic start_32(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      check("ready32_before_start", 64'(ready32), 64'd1);
      a32 = a; b32 = b; sm32 = s; start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      check("busy32_after_accept", 64'(busy32), 64'd1);
   endtask

   task automatic wait_done32(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!done32 && cyc < 200);
   endtask

   task automatic finish_32(input string tag, input int cyc, input logic [63:0] exp);
      check({tag, "_latency"}, 64'(cyc), 64'(LAT32));
      check({tag, "_product"}, p32, exp);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, 64'(done32), 64'd0);
      check({tag, "_ready_after"}, 64'(ready32), 64'd1);
      check({tag, "_product_held"}, p32, exp);
   endtask

   task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
      int cyc;
      start_32(a, b, s);
      wait_done32(cyc);
      finish_32(tag, cyc, model32(a, b, s));
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
      int cyc;
      @(negedge clk);
      a8 = a; b8 = b; sm8 = s; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!done8 && cyc < 100);
      check({tag, "_latency"}, 64'(cyc), 64'(LAT8));
      check({tag, "_product"}, 64'(p8), 64'(model8(a, b, s)));
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, 64'(done8), 64'd0);
   endtask

   initial begin
      int cyc;
      logic [63:0] exp;
      rst_n = 1'b0;
      start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
      start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
      #1;
      check("reset_ready", 64'(ready32), 64'd1);
      check("reset_busy", 64'(busy32), 64'd0);
      check("reset_done", 64'(done32), 64'd0);
      check("reset_product", p32, 64'd0);
      check("reset_product8", 64'(p8), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run32("3x5", 32'd3, 32'd5, 1'b0);
      check("3x5_literal", p32, 64'd15);
      run32("ffff_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("ffff_sq_literal", p32, 64'hFFFF_FFFE_0000_0001);
      run32("neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      check("neg3x5_literal", p32, 64'hFFFF_FFFF_FFFF_FFF1);
`else
      check("neg3x5_literal", p32, 64'h0000_0004_FFFF_FFF1);
`endif
      run32("minneg_sq", 32'h8000_0000, 32'h8000_0000, 1'b1);
      check("minneg_sq_literal", p32, 64'h4000_0000_0000_0000);
      run32("minneg_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

      // Second start mid-run must be ignored.
      start_32(32'd1234, 32'd5678, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      a32 = 32'd99; b32 = 32'd77; start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      wait_done32(cyc);
      finish_32("ignore_start", cyc + 11, 64'd1234 * 64'd5678);

      // Reset mid-run: outputs return to reset values at once, no done pulse.
      start_32(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      repeat (16) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_ready", 64'(ready32), 64'd1);
      check("midreset_busy", 64'(busy32), 64'd0);
      check("midreset_done", 64'(done32), 64'd0);
      check("midreset_product", p32, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("midreset_no_done", 64'(done32), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a32 = 32'd7; b32 = 32'd9; sm32 = 1'b0; start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      check("post_reset_accept", 64'(busy32), 64'd1);
      wait_done32(cyc);
      finish_32("7x9", cyc, 64'd63);

      // Product must stay put across idle cycles.
      repeat (4) @(posedge clk);
      #1;
      check("idle_product_hold", p32, 64'd63);

      for (int i = 0; i < 12; i++) begin
         logic [31:0] ra, rb;
         logic        rs;
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (i == 0) ra = 32'h8000_0000;
         if (i == 1) rb = 32'h0;
         run32("rand32", ra, rb, rs);
      end

      run8("w8_ff_sq", 8'hFF, 8'hFF, 1'b0);
      check("w8_ff_sq_literal", 64'(p8), 64'hFE01);
      run8("w8_minneg_sq", 8'h80, 8'h80, 1'b1);
      for (int i = 0; i < 8; i++) begin
         run8("rand8", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      exp = model32(32'hFFFF_FFFD, 32'd5, 1'b1);
      check("final_idle_ready", 64'(ready32), 64'd1);
      if (exp == 64'd0) $display("unexpected zero model value");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the operand width in bits; legal values are 2 to 64.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only while ready is high.
REQ-005 SHALL have port signed_mode, input, 1 bit: operands are two's complement when high; sampled with start.
REQ-006 SHALL have port multiplier, input, WIDTH bits: operand A, latched on start acceptance.
REQ-007 SHALL have port multiplicand, input, WIDTH bits: operand B, latched on start acceptance.
REQ-008 SHALL have port ready, output, 1 bit: block is idle and will accept start.
REQ-009 SHALL have port busy, output, 1 bit: a multiply is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking product valid.
REQ-011 SHALL have port product, output, 2*WIDTH bits: registered result.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, NEG, DONE, where ready = (state==IDLE), busy = (state==RUN or NEG), and done = (state==DONE).
REQ-013 SHALL accept start only in IDLE: at that edge latch the operands and signed_mode, load product with {WIDTH'0, multiplier magnitude}, clear the iteration counter, and go to RUN.
REQ-014 SHALL ignore start outside IDLE, leaving operands, product and timing unaffected.
REQ-015 SHALL, in RUN, perform one shift-add iteration per cycle: if product[0]=1, add the multiplicand magnitude to product[2W-1:W] with a (WIDTH+1)-bit sum; then shift {carry, sum, low half} right by one; then increment the counter.
REQ-016 SHALL leave RUN after exactly WIDTH iterations, using a counter of clog2(WIDTH+1) bits that never wraps.
REQ-017 SHALL, from RUN, go to NEG when compiled per REQ-025, otherwise to DONE.
REQ-018 SHALL, in NEG, replace product with its two's-complement negation if the latched signed_mode=1 and the operand signs differ, otherwise keep product, and go to DONE.
REQ-019 SHALL stay in DONE for exactly one cycle and then return to IDLE; a start asserted during DONE is ignored.
REQ-020 SHALL hold product stable from DONE until the next accepted start.
REQ-021 SHALL produce the exact full 2*WIDTH-bit product, including most-negative operand cases in signed mode (e.g. -2^(W-1) * -2^(W-1) = 2^(2W-2)).
REQ-022 SHALL have latency, from the accept edge to the first cycle with done high, of WIDTH cycles without the macro and WIDTH+1 cycles with it, independent of operand values.

Reset
REQ-023 SHALL, while reset_n=0, immediately force state=IDLE, counter=0, product=0, ready=1, busy=0 and done=0, regardless of clock.
REQ-024 SHALL discard any in-flight operation on reset and accept a new start on the first rising edge after reset_n rises.

Configuration
REQ-025 SHALL honour signed_mode, include the NEG state, and convert operands to magnitudes on accept when macro SEQ_MULTIPLIER_SIGNED_EN is defined.
REQ-026 SHALL, when SEQ_MULTIPLIER_SIGNED_EN is undefined, keep the signed_mode port but ignore it, omit the NEG state, and treat all operands as unsigned.

Verification
REQ-027 SHALL cover: WIDTH=32, A=3, B=5, start=1 for one cycle -> done high exactly 32 cycles (no macro) or 33 cycles (macro) after the accept edge, with product=15.
REQ-028 SHALL cover: A=B=0xFFFFFFFF, signed_mode=0 -> product=0xFFFFFFFE00000001.
REQ-029 SHALL cover: A=0xFFFFFFFD, B=5, signed_mode=1 -> product=0xFFFFFFFFFFFFFFF1 with the macro, and 0x00000004FFFFFFF1 without it.
REQ-030 SHALL cover: start pulsed again at iteration 10 with different operands -> ignored, and the first result and timing are unchanged.
REQ-031 SHALL cover: reset_n driven low at iteration 16 -> outputs take their reset values in the same cycle with no done pulse, and a fresh 7*9 run yields 63.
REQ-032 SHALL cover: WIDTH=8, A=B=0xFF unsigned -> product=0xFE01 with done after 8 (or 9) cycles.
